pulse_retry_queue: RTL and testbench

//  Source-domain front end for the handshake pulse synchronizer. Accepts bursty

---
 rtl/pulse_retry_queue.sv | 117 +++++++++++
 tb/tb_pulse_retry_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_retry_queue.sv
// Source-domain event queue that issues pending events one at a time as sync_pulse and
// retries rejected pulses after a backoff. Optional statistics: PULSE_RETRY_STATS_EN.
module pulse_retry_queue #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned BACKOFF_CYC = 4,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              src_clk,
  input  logic              src_rst_n,
  input  logic              evt_in,
  input  logic              clr,
  input  logic              sync_fail,
  output logic              sync_pulse,
  output logic [CNT_W-1:0]  pending,
  output logic              full,
  output logic              overflow,
  output logic              busy,
  output logic [STAT_W-1:0] retry_cnt,
  output logic [STAT_W-1:0] deliver_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StCheck, StBackoff} state_e;

  localparam int unsigned BoW = (BACKOFF_CYC > 2) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [BoW-1:0] BoInit = (BACKOFF_CYC > 0) ? BoW'(BACKOFF_CYC - 1) : '0;

  state_e             state_q, state_d;
  logic [BoW-1:0]     bo_q, bo_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic               inc, dec;

  assign full = (pending_q == '1);

  always_comb begin
    state_d    = state_q;
    bo_d       = bo_q;
    dec        = (state_q == StCheck) && !sync_fail;
    // A simultaneous delivery frees a slot, so a full queue still accepts the event.
    inc        = evt_in && !(full && !dec);
    overflow_d = overflow_q | (evt_in && full && !dec);
    pending_d  = pending_q + CNT_W'(inc) - CNT_W'(dec);

    case (state_q)
      StIdle: begin
        if (pending_q != '0) state_d = StIssue;
      end
      StIssue: state_d = StCheck;
      StCheck: begin
        if (!sync_fail) begin
          state_d = StIdle;
        end else if (BACKOFF_CYC == 0) begin
          state_d = StIssue;
        end else begin
          state_d = StBackoff;
          bo_d    = BoInit;
        end
      end
      StBackoff: begin
        if (bo_q == '0) state_d = StIssue;
        else            bo_d    = bo_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d    = StIdle;
      bo_d       = '0;
      pending_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state_q    <= StIdle;
      bo_q       <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bo_q       <= bo_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign sync_pulse = (state_q == StIssue);
  assign busy       = (state_q != StIdle);
  assign pending    = pending_q;
  assign overflow   = overflow_q;

`ifdef PULSE_RETRY_STATS_EN
  logic [STAT_W-1:0] retry_q, deliver_q;

  // Results are counted even in a clr cycle: the pulse was really issued.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      retry_q   <= '0;
      deliver_q <= '0;
    end else if (state_q == StCheck) begin
      if (sync_fail) begin
        if (retry_q != '1) retry_q <= retry_q + 1'b1;
      end else begin
        if (deliver_q != '1) deliver_q <= deliver_q + 1'b1;
      end
    end
  end

  assign retry_cnt   = retry_q;
  assign deliver_cnt = deliver_q;
`else
  assign retry_cnt   = '0;
  assign deliver_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_retry_queue.sv
// Randomized bench for pulse_retry_queue against a schedule-based reference model, plus
// directed scenarios with literal expectations.
module tb_pulse_retry_queue;

  localparam int CntW   = 8;
  localparam int Bo     = 4;
  localparam int StatW  = 16;
  localparam int MaxP   = (1 << CntW) - 1;
  localparam int MaxS   = (1 << StatW) - 1;

  logic             src_clk = 1'b0;
  logic             src_rst_n = 1'b0;
  logic             evt_in = 1'b0, clr = 1'b0, sync_fail = 1'b0;
  logic             sync_pulse, full, overflow, busy;
  logic [CntW-1:0]  pending;
  logic [StatW-1:0] retry_cnt, deliver_cnt;

  pulse_retry_queue #(.CNT_W(CntW), .BACKOFF_CYC(Bo), .STAT_W(StatW)) dut (
    .src_clk     (src_clk),
    .src_rst_n   (src_rst_n),
    .evt_in      (evt_in),
    .clr         (clr),
    .sync_fail   (sync_fail),
    .sync_pulse  (sync_pulse),
    .pending     (pending),
    .full        (full),
    .overflow    (overflow),
    .busy        (busy),
    .retry_cnt   (retry_cnt),
    .deliver_cnt (deliver_cnt)
  );

  always #5 src_clk = ~src_clk;

  int n_chk = 0, n_fail = 0;
  // Model: cycle index, queue depth, and the cycles at which the next pulse / result occur.
  int n = 0, m_pend = 0, pulse_at = -1, check_at = -1, m_retry = 0, m_deliver = 0;
  bit m_ovf = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  task automatic cmp();
    bit idle;
    int er, ed;
    idle = (pulse_at < 0) && (check_at != n);
    if (idle && m_pend > 0) pulse_at = n + 1;
`ifdef PULSE_RETRY_STATS_EN
    er = m_retry; ed = m_deliver;
`else
    er = 0; ed = 0;
`endif
    chk("sync_pulse", int'(sync_pulse), int'(pulse_at == n));
    chk("pending", int'(pending), m_pend);
    chk("full", int'(full), int'(m_pend == MaxP));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("busy", int'(busy), int'(!idle));
    chk("retry_cnt", int'(retry_cnt), er);
    chk("deliver_cnt", int'(deliver_cnt), ed);
  endtask

  task automatic model_update(input bit e, input bit f, input bit c);
    bit dec;
    dec = 0;
    if (check_at == n) begin
      if (f) m_retry = (m_retry < MaxS) ? m_retry + 1 : MaxS;
      else   m_deliver = (m_deliver < MaxS) ? m_deliver + 1 : MaxS;
    end
    if (c) begin
      m_pend = 0; m_ovf = 0; pulse_at = -1; check_at = -1;
    end else begin
      if (pulse_at == n) begin
        check_at = n + 1;
        pulse_at = -1;
      end else if (check_at == n) begin
        if (f) pulse_at = n + 1 + Bo;
        else   dec = 1;
      end
      if (e && m_pend == MaxP && !dec) m_ovf = 1;
      else m_pend = m_pend + int'(e) - int'(dec);
    end
    n++;
  endtask

  task automatic tick(input bit e, input bit f, input bit c);
    evt_in = e; sync_fail = f; clr = c;
    model_update(e, f, c);
    @(negedge src_clk);
    cmp();
  endtask

  int last_p, npulse, r0, d0, rej;
  bit done;

  initial begin
    #3;
    chk("reset pending", int'(pending), 0);
    chk("reset sync_pulse", int'(sync_pulse), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overflow", int'(overflow), 0);
    @(negedge src_clk);
    src_rst_n = 1'b1;
    cmp();

    // Single event: pulse two cycles later, queue empty and idle after the accept.
    tick(1, 0, 0); chk("t1 pending c1", int'(pending), 1); chk("t1 pulse c1", int'(sync_pulse), 0);
    tick(0, 0, 0); chk("t1 pulse c2", int'(sync_pulse), 1);
    tick(0, 0, 0); chk("t1 pulse c3", int'(sync_pulse), 0); chk("t1 pending c3", int'(pending), 1);
    tick(0, 0, 0); chk("t1 pending c4", int'(pending), 0); chk("t1 busy c4", int'(busy), 0);

    // Reject then retry: second pulse six cycles after the first.
    tick(1, 0, 0);
    tick(0, 0, 0); chk("t2 first pulse", int'(sync_pulse), 1);
    tick(0, 0, 0);
    tick(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2 no pulse in backoff", int'(sync_pulse), 0);
      chk("t2 pending held", int'(pending), 1);
      tick(0, 0, 0);
    end
    chk("t2 retry pulse", int'(sync_pulse), 1);
    tick(0, 0, 0); chk("t2 pending in check", int'(pending), 1);
    tick(0, 0, 0); chk("t2 pending after accept", int'(pending), 0);

    // Burst of ten events.
    last_p = -1; npulse = 0;
    for (int k = 0; k < 45; k++) begin
      tick(k < 10, 0, 0);
      if (sync_pulse) begin
        if (last_p >= 0) chk("t3 pulse spacing", n - last_p, 3);
        last_p = n; npulse++;
      end
    end
    chk("t3 pulse count", npulse, 10);
    chk("t3 final pending", int'(pending), 0);
    chk("t3 overflow", int'(overflow), 0);

    // Saturate the queue with every pulse rejected.
    for (int k = 0; k < MaxP + 5; k++) tick(1, 1, 0);
    chk("t4 pending sat", int'(pending), MaxP);
    chk("t4 full", int'(full), 1);
    chk("t4 overflow", int'(overflow), 1);
    for (int k = 0; k < 5; k++) tick(0, 1, 0);
    chk("t4 overflow sticky", int'(overflow), 1);
    tick(0, 0, 1);
    chk("t4 clr pending", int'(pending), 0);
    chk("t4 clr overflow", int'(overflow), 0);
    chk("t4 clr full", int'(full), 0);

    // clr during backoff with two events queued.
    tick(1, 0, 0);
    tick(1, 0, 0); chk("t5 pulse", int'(sync_pulse), 1); chk("t5 pending", int'(pending), 2);
    tick(0, 0, 0);
    tick(0, 1, 0); chk("t5 in backoff", int'(busy), 1);
    tick(0, 0, 1);
    chk("t5 pending", int'(pending), 0);
    chk("t5 busy", int'(busy), 0);
    chk("t5 overflow", int'(overflow), 0);
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0);
      npulse += int'(sync_pulse);
    end
    chk("t5 no pulse after clr", npulse, 0);

    // Two rejects then one accept.
    r0 = int'(retry_cnt); d0 = int'(deliver_cnt); rej = 0; done = 0;
    tick(1, 0, 0);
    for (int k = 0; k < 40 && !done; k++) begin
      if (check_at == n && rej < 2) begin
        rej++; tick(0, 1, 0);
      end else if (check_at == n) begin
        done = 1; tick(0, 0, 0);
      end else begin
        tick(0, 0, 0);
      end
    end
    chk("t6 accepted", int'(done), 1);
`ifdef PULSE_RETRY_STATS_EN
    chk("t6 retry delta", int'(retry_cnt) - r0, 2);
    chk("t6 deliver delta", int'(deliver_cnt) - d0, 1);
`else
    chk("t6 retry_cnt", int'(retry_cnt), 0);
    chk("t6 deliver_cnt", int'(deliver_cnt), 0);
`endif

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
